// File: rtl/blit_rdcap_pkg.sv
// Shared blitter definitions: read-kind tags, tag type, default phrase width.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package blit_rdcap_pkg;

   localparam int DW_DEF = 64;

   typedef logic [2:0] tag_t;

   localparam tag_t TAG_SRC   = 3'd0;
   localparam tag_t TAG_SRCX  = 3'd1;
   localparam tag_t TAG_DST   = 3'd2;
   localparam tag_t TAG_DSTZ  = 3'd3;
   localparam tag_t TAG_SRCZ1 = 3'd4;
   localparam tag_t TAG_SRCZ2 = 3'd5;

   // Both source kinds shift the source history the same way.
   function automatic logic is_src(input tag_t t);
      return (t == TAG_SRC) || (t == TAG_SRCX);
   endfunction

endpackage

// File: rtl/blit_tagfifo.sv
// Tag FIFO: DEPTH x 3-bit circular buffer holding the kind of each issued read.
// Latency: push visible at head the edge after it is written; head is combinational from state.
// Backpressure: none; push while full (no pop) is dropped and flagged ovf, pop while empty flagged unf.
//
// Ports: clk, reset (async, active-high); push/push_tag write side; pop consumes head;
//        head, count, full, empty status; ovf/unf are same-cycle error indications.
module blit_tagfifo
   import blit_rdcap_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [2:0]    push_tag,
   input  logic          pop,
   output logic [2:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          unf
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   tag_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign head  = mem[rd_ptr];

   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | pop);
   assign ovf     = push & full & ~pop;
   assign unf     = pop & empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_tag;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/blit_rdcap.sv
// Blitter read-data capture: steers each completed read phrase into its data register by issued kind.
// Latency: 1 clock from read_ack to data register / load pulse.
// Backpressure: none; tag overflow and ack-while-empty are dropped and recorded in sticky flags.
//
// Ports: clk, reset (async, active-high); rd_issue/rd_tag record a read; read_ack/data complete it;
//        clr_err clears sticky errors; srcd, srcd_prev, dstd, dstz, srcz1, srcz2 data registers;
//        ld_* one-cycle load pulses; tag_empty/tag_full/tag_count FIFO status; err_ovf/err_unf sticky.
module blit_rdcap
   import blit_rdcap_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = DW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rd_issue,
   input  logic [2:0]               rd_tag,
   input  logic                     read_ack,
   input  logic [DW-1:0]            data,
   input  logic                     clr_err,
   output logic [DW-1:0]            srcd,
   output logic [DW-1:0]            srcd_prev,
   output logic [DW-1:0]            dstd,
   output logic [DW-1:0]            dstz,
   output logic [DW-1:0]            srcz1,
   output logic [DW-1:0]            srcz2,
   output logic                     ld_src,
   output logic                     ld_dst,
   output logic                     ld_dstz,
   output logic                     ld_srcz,
   output logic                     tag_empty,
   output logic                     tag_full,
   output logic [$clog2(DEPTH):0]   tag_count,
   output logic                     err_ovf,
   output logic                     err_unf
);

   tag_t head;
   logic fifo_ovf;
   logic fifo_unf;
   logic pop_vld;
   logic sel_src;
   logic sel_dst;
   logic sel_dstz;
   logic sel_z1;
   logic sel_z2;

   blit_tagfifo #(.DEPTH(DEPTH)) u_tagfifo (
      .clk      (clk),
      .reset    (reset),
      .push     (rd_issue),
      .push_tag (rd_tag),
      .pop      (read_ack),
      .head     (head),
      .count    (tag_count),
      .full     (tag_full),
      .empty    (tag_empty),
      .ovf      (fifo_ovf),
      .unf      (fifo_unf)
   );

   // No bypass: an ack only steers data when a tag was already held before this edge.
   assign pop_vld = read_ack & ~tag_empty;

   // Reserved tags fall through with every select low: popped, data dropped silently.
   always_comb begin
      sel_src  = 1'b0;
      sel_dst  = 1'b0;
      sel_dstz = 1'b0;
      sel_z1   = 1'b0;
      sel_z2   = 1'b0;
      if (pop_vld) begin
         sel_src = is_src(head);
         case (head)
            TAG_DST:   sel_dst  = 1'b1;
            TAG_DSTZ:  sel_dstz = 1'b1;
            TAG_SRCZ1: sel_z1   = 1'b1;
            TAG_SRCZ2: sel_z2   = 1'b1;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         srcd      <= '0;
         srcd_prev <= '0;
         dstd      <= '0;
         dstz      <= '0;
         srcz1     <= '0;
         srcz2     <= '0;
         ld_src    <= 1'b0;
         ld_dst    <= 1'b0;
         ld_dstz   <= 1'b0;
         ld_srcz   <= 1'b0;
      end else begin
         if (sel_src) begin
            srcd_prev <= srcd;
            srcd      <= data;
         end
         if (sel_dst)  dstd  <= data;
         if (sel_dstz) dstz  <= data;
         if (sel_z1)   srcz1 <= data;
         if (sel_z2)   srcz2 <= data;
         ld_src  <= sel_src;
         ld_dst  <= sel_dst;
         ld_dstz <= sel_dstz;
         ld_srcz <= sel_z1 | sel_z2;
      end
   end

   // Sticky errors: a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         err_ovf <= (err_ovf & ~clr_err) | fifo_ovf;
         err_unf <= (err_unf & ~clr_err) | fifo_unf;
      end
   end

endmodule
